// File: rtl/hazard_interlock_unit.sv
`default_nettype none
// ============================================================================
// hazard_interlock_unit: load-use interlock, EX forwarding selects, stats
// Rev 1.0
// ============================================================================
module hazard_interlock_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_r1_used,
  input  logic             id_r2_used,
  input  logic [4:0]       id_rd,
  input  logic             id_reg_write,
  input  logic             id_is_load,
  output logic             stall,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  // WB-stage producers are bypassed by the register file, so only EX and MEM
  // entries influence the outputs and need to be stored here.
  logic       r_ex_valid, r_ex_we, r_ex_load;
  logic [4:0] r_ex_rd;
  logic       r_mem_valid, r_mem_we;
  logic [4:0] r_mem_rd;

  logic       w_ex_prod, w_mem_prod, w_stall, w_id_adv;
  logic [1:0] w_fwd_a_nxt, w_fwd_b_nxt;

  assign w_ex_prod  = r_ex_valid  & r_ex_we  & (r_ex_rd  != 5'd0);
  assign w_mem_prod = r_mem_valid & r_mem_we & (r_mem_rd != 5'd0);

  assign w_stall = id_valid & ~flush & ~halt & w_ex_prod & r_ex_load &
                   ((id_r1_used & (id_rs1 == r_ex_rd)) |
                    (id_r2_used & (id_rs2 == r_ex_rd)));
  assign stall    = w_stall;
  assign w_id_adv = id_valid & ~w_stall & ~flush;

  // A load in EX never forwards from EX/MEM; the interlock covers that case.
  always_comb begin
    w_fwd_a_nxt = 2'b00;
    w_fwd_b_nxt = 2'b00;
    if (w_id_adv && id_r1_used) begin
      if (w_ex_prod && !r_ex_load && (r_ex_rd == id_rs1))
        w_fwd_a_nxt = 2'b01;
      else if (w_mem_prod && (r_mem_rd == id_rs1))
        w_fwd_a_nxt = 2'b10;
    end
    if (w_id_adv && id_r2_used) begin
      if (w_ex_prod && !r_ex_load && (r_ex_rd == id_rs2))
        w_fwd_b_nxt = 2'b01;
      else if (w_mem_prod && (r_mem_rd == id_rs2))
        w_fwd_b_nxt = 2'b10;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_valid  <= 1'b0;
      r_ex_we     <= 1'b0;
      r_ex_load   <= 1'b0;
      r_ex_rd     <= 5'd0;
      r_mem_valid <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_rd    <= 5'd0;
      fwd_a       <= 2'b00;
      fwd_b       <= 2'b00;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else if (!halt) begin
      r_mem_valid <= r_ex_valid;
      r_mem_we    <= r_ex_we;
      r_mem_rd    <= r_ex_rd;
      r_ex_valid  <= w_id_adv;
      r_ex_we     <= id_reg_write;
      r_ex_load   <= id_is_load;
      r_ex_rd     <= id_rd;
      fwd_a       <= w_fwd_a_nxt;
      fwd_b       <= w_fwd_b_nxt;
      if (w_stall && (stall_cnt != C_CNT_MAX))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && (flush_cnt != C_CNT_MAX))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire
